// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream, imem write and status bundle for imem_loader
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  core_rst_n;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, addr, data, valid, core_rst_n, busy, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, addr, data, valid, core_rst_n, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader filling imem from a length-prefixed little-endian byte stream
module imem_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_WORDS = 512
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, WORD, WRITE, DONE, ERR} state_t;

  localparam logic [16:0] MAX_N = 17'(IMEM_WORDS);

  state_t      state;
  logic [15:0] len;
  logic [15:0] idx;
  logic [1:0]  bcnt;
  logic [23:0] word_buf;
  logic        xfer;
  logic [15:0] len_next;
  logic [15:0] idx_next;

  assign xfer     = bus.byte_valid & bus.byte_ready;
  assign len_next = {bus.byte_in, len[7:0]};
  assign idx_next = idx + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      len            <= '0;
      idx            <= '0;
      bcnt           <= '0;
      word_buf       <= '0;
      bus.byte_ready <= 1'b0;
      bus.valid      <= 1'b0;
      bus.addr       <= '0;
      bus.data       <= '0;
      bus.core_rst_n <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (bus.start) begin
            state          <= LEN0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.core_rst_n <= 1'b0;
            bus.busy       <= 1'b1;
            bus.byte_ready <= 1'b1;
            idx            <= '0;
            bcnt           <= '0;
          end
        end
        LEN0: begin
          if (xfer) begin
            len[7:0] <= bus.byte_in;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (xfer) begin
            len[15:8] <= bus.byte_in;
            if (len_next == 16'd0) begin
              state          <= DONE;
              bus.byte_ready <= 1'b0;
              bus.busy       <= 1'b0;
              bus.done       <= 1'b1;
              bus.core_rst_n <= 1'b1;
            end else if ({1'b0, len_next} > MAX_N) begin
              state          <= ERR;
              bus.byte_ready <= 1'b0;
              bus.busy       <= 1'b0;
              bus.err        <= 1'b1;
            end else begin
              state <= WORD;
            end
          end
        end
        WORD: begin
          // Bytes assemble off to the side so addr/data only move when the strobe fires.
          if (xfer) begin
            bcnt <= bcnt + 2'd1;
            case (bcnt)
              2'd0: word_buf[7:0]   <= bus.byte_in;
              2'd1: word_buf[15:8]  <= bus.byte_in;
              2'd2: word_buf[23:16] <= bus.byte_in;
              default: begin
                bus.data       <= DATA_WIDTH'({bus.byte_in, word_buf});
                bus.addr       <= ADDR_WIDTH'(idx);
                bus.valid      <= 1'b1;
                bus.byte_ready <= 1'b0;
                state          <= WRITE;
              end
            endcase
          end
        end
        WRITE: begin
          idx <= idx_next;
          if (idx_next == len) begin
            state          <= DONE;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
            bus.core_rst_n <= 1'b1;
          end else begin
            state          <= WORD;
            bus.byte_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with directed byte streams
module tb_imem_loader;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [63:0] exp_q[$];

  imem_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  imem_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IMEM_WORDS(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected (addr, data).
  always @(negedge clk) begin
    if (!rst && bus.valid === 1'b1) begin
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.addr, bus.data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.addr, bus.data} !== e) begin
          errors++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   bus.addr, bus.data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget;
    bus.byte_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    budget = 0;
    while (bus.byte_ready !== 1'b1 && budget < 50) begin
      tick();
      budget++;
    end
    if (budget >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %0h never accepted, expected acceptance", b);
    end else begin
      tick();
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] a, input int gap);
    exp_q.push_back({a, w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic wait_not_busy();
    int budget;
    budget = 0;
    while (bus.busy === 1'b1 && budget < 50) begin
      tick();
      budget++;
    end
    chk("busy_timeout", 64'(budget >= 50), 64'd0);
    tick();
  endtask

  task automatic check_status(input string name, input logic d, input logic e, input logic c);
    chk({name, "_done"}, 64'(bus.done), 64'(d));
    chk({name, "_err"}, 64'(bus.err), 64'(e));
    chk({name, "_core_rst_n"}, 64'(bus.core_rst_n), 64'(c));
    chk({name, "_busy"}, 64'(bus.busy), 64'd0);
    chk({name, "_sb_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    chk({name, "_valid"}, 64'(bus.valid), 64'd0);
    chk({name, "_addr"}, 64'(bus.addr), 64'd0);
    chk({name, "_data"}, 64'(bus.data), 64'd0);
    chk({name, "_core_rst_n"}, 64'(bus.core_rst_n), 64'd0);
    chk({name, "_busy"}, 64'(bus.busy), 64'd0);
    chk({name, "_done"}, 64'(bus.done), 64'd0);
    chk({name, "_err"}, 64'(bus.err), 64'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();

    // 1: two-word program
    do_start();
    chk("t1_busy", 64'(bus.busy), 64'd1);
    chk("t1_byte_ready", 64'(bus.byte_ready), 64'd1);
    send_len(16'd2);
    send_word(32'h0000_0013, 32'd0, 0);
    chk("t1_valid_latency", 64'(bus.valid), 64'd1);
    send_word(32'h0000_006F, 32'd1, 0);
    wait_not_busy();
    check_status("t1", 1'b1, 1'b0, 1'b1);

    // 2: empty program, started from DONE
    do_start();
    chk("t2_core_rst_drop", 64'(bus.core_rst_n), 64'd0);
    chk("t2_done_clear", 64'(bus.done), 64'd0);
    send_len(16'd0);
    wait_not_busy();
    check_status("t2", 1'b1, 1'b0, 1'b1);

    // 3: oversize length
    do_start();
    send_len(16'h0201);
    wait_not_busy();
    check_status("t3", 1'b0, 1'b1, 1'b0);
    bus.byte_in = 8'h55;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_byte_ready_low", 64'(bus.byte_ready), 64'd0);
    end
    bus.byte_valid = 1'b0;

    // 4: gapped bytes plus a stray byte during WRITE
    do_start();
    send_len(16'd1);
    exp_q.push_back({32'd0, 32'hDEAD_BEEF});
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 1);
    send_byte(8'hAD, 2);
    send_byte(8'hDE, 3);
    bus.byte_in = 8'hEE;
    bus.byte_valid = 1'b1;
    tick();
    bus.byte_valid = 1'b0;
    wait_not_busy();
    check_status("t4", 1'b1, 1'b0, 1'b1);
    chk("t4_data_hold", 64'(bus.data), 64'hDEAD_BEEF);

    // 5: reset in the middle of a word
    do_start();
    send_len(16'd1);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    #2;
    check_reset_values("t5_rst");
    tick();
    rst = 1'b0;
    tick();
    do_start();
    send_len(16'd1);
    send_word(32'h4433_2211, 32'd0, 1);
    wait_not_busy();
    check_status("t5", 1'b1, 1'b0, 1'b1);

    // 6: full-depth load with start pulses that must be ignored
    do_start();
    send_len(16'd512);
    for (int k = 0; k < 512; k++) begin
      if (k % 100 == 50) bus.start = 1'b1;
      send_word(32'hA500_0000 ^ (32'(k) * 32'd2654435), 32'(k), 0);
      bus.start = 1'b0;
      if (k % 100 == 50) chk("t6_still_busy", 64'(bus.busy), 64'(k != 511));
    end
    wait_not_busy();
    check_status("t6", 1'b1, 1'b0, 1'b1);
    chk("t6_last_addr", 64'(bus.addr), 64'd511);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
